// File: rtl/mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : mc_ctrl_fsm
//  Purpose  : Multi-cycle control sequencer for the MIPS-lite datapath
//             (IFU, GRF, ALU, EXT, DM). Steps each instruction through
//             FETCH/DECODE/EXEC/MEMACC/WB and drives every datapath strobe.
//             DM may be variable-latency; MEMACC waits on MemReady with an
//             optional timeout abort.
//  Ports    : Clk, Reset (async, active-low)
//             Op, Func       - instruction fields, sampled in DECODE
//             Zero           - ALU equal flag (beq in EXEC)
//             MemReady       - DM completion for MemRead/MemWrite
//             PCWrite, NPCSel, IRWrite, RegWrite, RegDst, ALUSrc, ExtOp,
//             ALUCtrl, MemRead, MemWrite, MemToReg - datapath strobes
//             Retire, MemErr - completion / abort pulses
//             State          - current state code
//  Config   : ILLEGAL_TRAP_EN - when defined, an unknown instruction parks
//             the sequencer in HALT until Reset; otherwise it is a NOP.
//  Revision : 1.0 - initial release
// ============================================================================
module mc_ctrl_fsm #(
    parameter int TIMEOUT_CYC = 16,   // 0 disables the MEMACC timeout
    parameter int TMO_W       = 5
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [5:0] Op,
    input  logic [5:0] Func,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic [1:0] NPCSel,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic       ALUSrc,
    output logic       ExtOp,
    output logic [2:0] ALUCtrl,
    output logic       MemRead,
    output logic       MemWrite,
    output logic [1:0] MemToReg,
    output logic       Retire,
    output logic       MemErr,
    output logic [2:0] State
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEMACC = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        C_NOP  = 4'd0,
        C_ADDU = 4'd1,
        C_SUBU = 4'd2,
        C_JR   = 4'd3,
        C_ORI  = 4'd4,
        C_LW   = 4'd5,
        C_SW   = 4'd6,
        C_BEQ  = 4'd7,
        C_LUI  = 4'd8,
        C_JAL  = 4'd9
    } cls_t;

    localparam logic [TMO_W-1:0] c_TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    state_t           r_state;
    cls_t             r_cls;
    logic [TMO_W-1:0] r_cnt;
    cls_t             w_dec_cls;
    logic             w_tmo;

    // Last allowed wait cycle; MemReady on this cycle still completes.
    assign w_tmo = (TIMEOUT_CYC != 0) && (r_cnt == c_TMO_LAST);

    // Instruction class decode (only consumed in DECODE)
    always_comb begin
        w_dec_cls = C_NOP;
        case (Op)
            6'b000000: begin
                case (Func)
                    6'b100001: w_dec_cls = C_ADDU;
                    6'b100011: w_dec_cls = C_SUBU;
                    6'b001000: w_dec_cls = C_JR;
                    default:   w_dec_cls = C_NOP;
                endcase
            end
            6'b001101: w_dec_cls = C_ORI;
            6'b100011: w_dec_cls = C_LW;
            6'b101011: w_dec_cls = C_SW;
            6'b000100: w_dec_cls = C_BEQ;
            6'b001111: w_dec_cls = C_LUI;
            6'b000011: w_dec_cls = C_JAL;
            default:   w_dec_cls = C_NOP;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_FETCH;
            r_cls   <= C_NOP;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_FETCH: r_state <= S_DECODE;
                S_DECODE: begin
                    r_cls <= w_dec_cls;
                    if (w_dec_cls == C_JAL)
                        r_state <= S_WB;
                    else if (w_dec_cls == C_NOP)
`ifdef ILLEGAL_TRAP_EN
                        r_state <= S_HALT;
`else
                        r_state <= S_FETCH;
`endif
                    else
                        r_state <= S_EXEC;
                end
                S_EXEC: begin
                    case (r_cls)
                        C_LW, C_SW: begin
                            r_state <= S_MEMACC;
                            r_cnt   <= '0;
                        end
                        C_ADDU, C_SUBU, C_ORI, C_LUI: r_state <= S_WB;
                        default:                      r_state <= S_FETCH;
                    endcase
                end
                S_MEMACC: begin
                    if (MemReady) begin
                        r_cnt   <= '0;
                        r_state <= (r_cls == C_LW) ? S_WB : S_FETCH;
                    end else if (w_tmo) begin
                        r_cnt   <= '0;
                        r_state <= S_FETCH;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                S_WB:    r_state <= S_FETCH;
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    // Strobe decode; everything is forced low while Reset is asserted so the
    // FETCH reset state cannot leak IRWrite/PCWrite.
    always_comb begin
        PCWrite  = 1'b0;
        NPCSel   = 2'b00;
        IRWrite  = 1'b0;
        RegWrite = 1'b0;
        RegDst   = 2'b00;
        ALUSrc   = 1'b0;
        ExtOp    = 1'b0;
        ALUCtrl  = 3'b000;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemToReg = 2'b00;
        Retire   = 1'b0;
        MemErr   = 1'b0;
        State    = 3'd0;
        if (Reset) begin
            State = r_state;
            case (r_state)
                S_FETCH: begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                end
                S_EXEC: begin
                    case (r_cls)
                        C_ADDU: ALUCtrl = 3'b000;
                        C_SUBU: ALUCtrl = 3'b001;
                        C_ORI, C_LUI: begin
                            ALUSrc  = 1'b1;
                            ALUCtrl = 3'b010;
                        end
                        C_LW, C_SW: begin
                            ALUSrc = 1'b1;
                            ExtOp  = 1'b1;
                        end
                        C_BEQ: begin
                            ALUCtrl = 3'b001;
                            ExtOp   = 1'b1;
                            NPCSel  = 2'b01;
                            PCWrite = Zero;
                            Retire  = 1'b1;
                        end
                        C_JR: begin
                            NPCSel  = 2'b11;
                            PCWrite = 1'b1;
                            Retire  = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_MEMACC: begin
                    ALUSrc   = 1'b1;
                    ExtOp    = 1'b1;
                    MemRead  = (r_cls == C_LW);
                    MemWrite = (r_cls == C_SW);
                    Retire   = MemReady && (r_cls == C_SW);
                    MemErr   = !MemReady && w_tmo;
                end
                S_WB: begin
                    RegWrite = 1'b1;
                    Retire   = 1'b1;
                    case (r_cls)
                        C_ADDU, C_SUBU: RegDst = 2'b01;
                        C_LUI:          MemToReg = 2'b11;
                        C_LW: begin
                            MemToReg = 2'b01;
                            ALUSrc   = 1'b1;
                            ExtOp    = 1'b1;
                        end
                        C_JAL: begin
                            RegDst   = 2'b10;
                            MemToReg = 2'b10;
                            PCWrite  = 1'b1;
                            NPCSel   = 2'b10;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mc_ctrl_fsm
//  Purpose  : Directed self-checking bench for mc_ctrl_fsm. Walks addu, subu,
//             lw with wait states, sw timeout / boundary / fast paths, beq,
//             jr, jal, lui, an illegal opcode and an asynchronous reset in
//             the middle of a memory access.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mc_ctrl_fsm;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [5:0] Op;
    logic [5:0] Func;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite;
    logic [1:0] NPCSel;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] RegDst;
    logic       ALUSrc;
    logic       ExtOp;
    logic [2:0] ALUCtrl;
    logic       MemRead;
    logic       MemWrite;
    logic [1:0] MemToReg;
    logic       Retire;
    logic       MemErr;
    logic [2:0] State;

    int checks = 0;
    int errors = 0;

    mc_ctrl_fsm #(.TIMEOUT_CYC(16), .TMO_W(5)) dut (
        .Clk(Clk), .Reset(Reset), .Op(Op), .Func(Func), .Zero(Zero),
        .MemReady(MemReady), .PCWrite(PCWrite), .NPCSel(NPCSel),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
        .ALUSrc(ALUSrc), .ExtOp(ExtOp), .ALUCtrl(ALUCtrl),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
        .Retire(Retire), .MemErr(MemErr), .State(State)
    );

    always #5 Clk = ~Clk;

    // All outputs packed, State in the low three bits.
    logic [20:0] all_out;
    assign all_out = {PCWrite, NPCSel, IRWrite, RegWrite, RegDst, ALUSrc, ExtOp,
                      ALUCtrl, MemRead, MemWrite, MemToReg, Retire, MemErr, State};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; return 2 time units after the rising edge.
    task automatic cyc();
        @(posedge Clk);
        #2;
    endtask

    int  rd_cnt;
    int  err_cnt;
    logic bad;

    initial begin
        Reset = 1'b0; Op = 6'h00; Func = 6'h00; Zero = 1'b0; MemReady = 1'b0;
        #2;
        chk("reset_all_zero", 32'(all_out), 32'd0);
        cyc();
        chk("reset_after_edge", 32'(all_out), 32'd0);
        Reset = 1'b1;
        #1;
        chk("fetch_irwrite", 32'(IRWrite), 32'd1);
        chk("fetch_pcwrite", 32'(PCWrite), 32'd1);
        chk("fetch_npcsel", 32'(NPCSel), 32'd0);
        chk("fetch_state", 32'(State), 32'd0);

        // addu
        Op = 6'h00; Func = 6'h21;
        cyc(); #1;
        chk("addu_decode_quiet", 32'(all_out), 32'd1);
        cyc(); #1;
        chk("addu_exec_quiet", 32'(all_out), 32'd2);
        cyc(); #1;
        chk("addu_wb_state", 32'(State), 32'd4);
        chk("addu_wb_regwrite", 32'(RegWrite), 32'd1);
        chk("addu_wb_regdst", 32'(RegDst), 32'd1);
        chk("addu_wb_memtoreg", 32'(MemToReg), 32'd0);
        chk("addu_wb_retire", 32'(Retire), 32'd1);
        cyc(); #1;
        chk("addu_back_fetch", 32'(State), 32'd0);

        // subu
        Func = 6'h23;
        cyc(); cyc(); #1;
        chk("subu_exec_aluctrl", 32'(ALUCtrl), 32'd1);
        chk("subu_exec_state", 32'(State), 32'd2);
        cyc(); #1;
        chk("subu_wb_regdst", 32'(RegDst), 32'd1);
        cyc(); #1;

        // lw, MemReady three cycles after MEMACC entry
        Op = 6'h23; Func = 6'h00;
        cyc(); cyc(); #1;
        chk("lw_exec_alusrc", 32'(ALUSrc), 32'd1);
        chk("lw_exec_extop", 32'(ExtOp), 32'd1);
        chk("lw_exec_memread", 32'(MemRead), 32'd0);
        rd_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            MemReady = (k == 3);
            #1;
            chk("lw_memacc_state", 32'(State), 32'd3);
            if (MemRead) rd_cnt++;
        end
        chk("lw_memacc_retire", 32'(Retire), 32'd0);
        cyc();
        MemReady = 1'b0;
        #1;
        chk("lw_memread_cycles", 32'(rd_cnt), 32'd4);
        chk("lw_wb_state", 32'(State), 32'd4);
        chk("lw_wb_memtoreg", 32'(MemToReg), 32'd1);
        chk("lw_wb_regwrite", 32'(RegWrite), 32'd1);
        chk("lw_wb_regdst", 32'(RegDst), 32'd0);
        chk("lw_wb_memread", 32'(MemRead), 32'd0);
        cyc(); #1;

        // sw, MemReady stuck low -> timeout in the 16th MEMACC cycle
        Op = 6'h2B;
        cyc(); cyc(); #1;
        bad = 1'b0; err_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            cyc(); #1;
            if (RegWrite || Retire) bad = 1'b1;
            if (MemErr) err_cnt++;
            if (k == 0)  chk("sw_tmo_memwrite", 32'(MemWrite), 32'd1);
            if (k == 15) chk("sw_tmo_memerr_16th", 32'(MemErr), 32'd1);
        end
        cyc(); #1;
        chk("sw_tmo_state_after", 32'(State), 32'd0);
        chk("sw_tmo_memerr_gone", 32'(MemErr), 32'd0);
        chk("sw_tmo_pulse_count", 32'(err_cnt), 32'd1);
        chk("sw_tmo_no_write", 32'(bad), 32'd0);

        // sw, MemReady on the last allowed cycle wins over the timeout
        cyc(); cyc(); #1;
        for (int k = 0; k < 16; k++) begin
            cyc();
            MemReady = (k == 15);
            #1;
        end
        chk("sw_edge_memerr", 32'(MemErr), 32'd0);
        chk("sw_edge_retire", 32'(Retire), 32'd1);
        cyc();
        MemReady = 1'b0;
        #1;
        chk("sw_edge_fetch", 32'(State), 32'd0);

        // sw, MemReady on the entry cycle
        cyc(); cyc(); cyc();
        MemReady = 1'b1;
        #1;
        chk("sw_fast_memwrite", 32'(MemWrite), 32'd1);
        chk("sw_fast_retire", 32'(Retire), 32'd1);
        cyc();
        MemReady = 1'b0;
        #1;
        chk("sw_fast_fetch", 32'(State), 32'd0);

        // beq not taken, then taken
        Op = 6'h04;
        cyc(); cyc();
        Zero = 1'b0;
        #1;
        chk("beq0_pcwrite", 32'(PCWrite), 32'd0);
        chk("beq0_npcsel", 32'(NPCSel), 32'd1);
        chk("beq0_retire", 32'(Retire), 32'd1);
        chk("beq0_aluctrl", 32'(ALUCtrl), 32'd1);
        cyc(); #1;
        chk("beq0_fetch", 32'(State), 32'd0);
        cyc(); cyc();
        Zero = 1'b1;
        #1;
        chk("beq1_pcwrite", 32'(PCWrite), 32'd1);
        chk("beq1_npcsel", 32'(NPCSel), 32'd1);
        chk("beq1_retire", 32'(Retire), 32'd1);
        cyc();
        Zero = 1'b0;
        #1;

        // jr
        Op = 6'h00; Func = 6'h08;
        cyc(); cyc(); #1;
        chk("jr_npcsel", 32'(NPCSel), 32'd3);
        chk("jr_pcwrite", 32'(PCWrite), 32'd1);
        chk("jr_retire", 32'(Retire), 32'd1);
        cyc(); #1;
        chk("jr_fetch", 32'(State), 32'd0);

        // jal goes straight from DECODE to WB
        Op = 6'h03; Func = 6'h00;
        cyc(); cyc(); #1;
        chk("jal_wb_state", 32'(State), 32'd4);
        chk("jal_wb_regdst", 32'(RegDst), 32'd2);
        chk("jal_wb_npcsel", 32'(NPCSel), 32'd2);
        chk("jal_wb_pcwrite", 32'(PCWrite), 32'd1);
        chk("jal_wb_memtoreg", 32'(MemToReg), 32'd2);
        cyc(); #1;

        // lui
        Op = 6'h0F;
        cyc(); cyc(); #1;
        chk("lui_exec_alusrc", 32'(ALUSrc), 32'd1);
        chk("lui_exec_extop", 32'(ExtOp), 32'd0);
        chk("lui_exec_aluctrl", 32'(ALUCtrl), 32'd2);
        cyc(); #1;
        chk("lui_wb_memtoreg", 32'(MemToReg), 32'd3);
        chk("lui_wb_regdst", 32'(RegDst), 32'd0);
        cyc(); #1;

        // illegal opcode
        Op = 6'h3F;
        cyc(); #1;
        chk("ill_decode_quiet", 32'(all_out), 32'd1);
`ifdef ILLEGAL_TRAP_EN
        for (int k = 0; k < 20; k++) begin
            cyc(); #1;
            chk("ill_halt_held", 32'(all_out), 32'd7);
        end
        Reset = 1'b0;
        #1;
        Reset = 1'b1;
        #1;
        chk("ill_halt_reset_exit", 32'(State), 32'd0);
`else
        cyc(); #1;
        chk("ill_nop_fetch", 32'(State), 32'd0);
        chk("ill_nop_retire", 32'(Retire), 32'd0);
`endif

        // Reset asserted mid-MEMACC of a sw
        Op = 6'h2B;
        cyc(); cyc(); cyc(); #1;
        chk("rst_mid_memwrite_before", 32'(MemWrite), 32'd1);
        #1;
        Reset = 1'b0;
        #1;
        chk("rst_mid_memwrite_drop", 32'(MemWrite), 32'd0);
        chk("rst_mid_all_zero", 32'(all_out), 32'd0);
        cyc();
        Reset = 1'b1;
        #1;
        chk("rst_rel_irwrite", 32'(IRWrite), 32'd1);
        chk("rst_rel_state", 32'(State), 32'd0);
        cyc(); #1;
        chk("rst_rel_decode_irwrite", 32'(IRWrite), 32'd0);
        chk("rst_rel_decode_state", 32'(State), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
